msrr8_load_seq: RTL

//   Upstream sequencer for the 8-bit multi-mode shift/rotate register (MSRR8).

---
 rtl/msrr8_load_seq.sv | 116 +++++++++++
 1 files changed

// File: rtl/msrr8_load_seq.sv
// Serial load/rotate sequencer for the MSRR8 shift register: shifts a captured
// byte in through sIn/mode, then issues a programmable number of rotates.
module msrr8_load_seq #(
  parameter int          WIDTH     = 8,
  parameter logic [1:0]  MODE_HOLD = 2'b00,
  parameter logic [1:0]  MODE_SHR  = 2'b01,
  parameter logic [1:0]  MODE_SHL  = 2'b10,
  parameter logic [1:0]  MODE_ROT  = 2'b11
) (
  input  logic             clc,
  input  logic             R,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  input  logic [2:0]       rot_n,
  output logic             sIn,
  output logic [1:0]       mode,
  output logic             ready,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ROT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] din_q;
  logic             dir_q;
  logic [2:0]       rot_q;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       rot_cnt;

  // Bit idx of the load sequence: LSB first for SHR, MSB first for SHL.
  function automatic logic load_bit(input logic [WIDTH-1:0] d,
                                    input logic msb_first,
                                    input logic [CNT_W-1:0] idx);
    return msb_first ? d[WIDTH-1-int'(idx)] : d[int'(idx)];
  endfunction

  assign ready = (state == S_IDLE);

  always_ff @(posedge clc) begin
    if (R) begin
      state   <= S_IDLE;
      sIn     <= 1'b0;
      mode    <= MODE_HOLD;
      busy    <= 1'b0;
      done    <= 1'b0;
      din_q   <= '0;
      dir_q   <= 1'b0;
      rot_q   <= '0;
      bit_cnt <= '0;
      rot_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          mode <= MODE_HOLD;
          sIn  <= 1'b0;
          if (start) begin
            din_q   <= din;
            dir_q   <= dir;
            rot_q   <= rot_n;
            bit_cnt <= '0;
            state   <= S_LOAD;
            busy    <= 1'b1;
            // Outputs for the first load bit are registered on the accept edge.
            mode    <= dir ? MODE_SHL : MODE_SHR;
            sIn     <= load_bit(din, dir, '0);
          end
        end
        S_LOAD: begin
          if (bit_cnt == LAST_BIT) begin
            sIn <= 1'b0;
            if (rot_q != 3'd0) begin
              state   <= S_ROT;
              mode    <= MODE_ROT;
              rot_cnt <= rot_q;
            end else begin
              state <= S_DONE;
              mode  <= MODE_HOLD;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            sIn     <= load_bit(din_q, dir_q, bit_cnt + 1'b1);
          end
        end
        S_ROT: begin
          rot_cnt <= rot_cnt - 3'd1;
          if (rot_cnt == 3'd1) begin
            state <= S_DONE;
            mode  <= MODE_HOLD;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          mode  <= MODE_HOLD;
          sIn   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
